// File: rtl/md5_pkg.sv
// md5_pkg -- shared definitions for the MD5 message padder.
//
// Contents:
//   md5_state_e     : padder FSM states (FILL, EMIT, EXTRA)
//   md5_block_t     : 64-byte block, packed so that message byte k lives at
//                     element [63-k], i.e. bits [511-8k -: 8] of the flat vector
//   MD5_BLOCK_BYTES : bytes per block (64)
//   MD5_LEN_POS     : first byte of the 64-bit length field (56)
//   MD5_PAD_BYTE    : the single-one pad marker (8'h80)
//   md5_insert_len  : writes the little-endian bit length into bytes 56..63
package md5_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    EXTRA = 2'd2
  } md5_state_e;

  typedef logic [63:0][7:0] md5_block_t;

  localparam int         MD5_BLOCK_BYTES = 64;
  localparam int         MD5_LEN_POS     = 56;
  localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;

  // Message byte k sits at element [63-k], so length byte 56 (the LSB of the
  // bit length) is element 7 and length byte 63 (the MSB) is element 0.
  function automatic md5_block_t md5_insert_len(input md5_block_t blk,
                                                input logic [63:0] bit_len);
    md5_block_t b;
    b    = blk;
    b[7] = bit_len[7:0];
    b[6] = bit_len[15:8];
    b[5] = bit_len[23:16];
    b[4] = bit_len[31:24];
    b[3] = bit_len[39:32];
    b[2] = bit_len[47:40];
    b[1] = bit_len[55:48];
    b[0] = bit_len[63:56];
    return b;
  endfunction

endpackage

// File: rtl/md5_padder_if.sv
// md5_padder_if -- byte stream in, padded 512-bit block out.
//
// Signals:
//   s_data[7:0]     message byte            (source -> padder)
//   s_valid         s_data valid            (source -> padder)
//   s_last          final byte of message   (source -> padder)
//   s_ready         byte accepted           (padder -> source)
//   blk_data[511:0] padded block, byte k at [511-8k -: 8] (padder -> sink)
//   blk_valid       blk_data valid          (padder -> sink)
//   blk_last        final block of message  (padder -> sink)
//   blk_ready       block consumed          (sink -> padder)
//
// Modports:
//   master : the environment (drives the byte stream, consumes blocks)
//   slave  : the padder
interface md5_padder_if;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready;

  modport master (
    output s_data, s_valid, s_last, blk_ready,
    input  s_ready, blk_data, blk_valid, blk_last
  );

  modport slave (
    input  s_data, s_valid, s_last, blk_ready,
    output s_ready, blk_data, blk_valid, blk_last
  );
endinterface

// File: rtl/md5_padder.sv
// md5_padder -- collects message bytes into 64-byte blocks and applies MD5
// padding (0x80 marker, zero fill, 64-bit little-endian bit length).
//
// Parameters:
//   CNT_W : width of the message byte counter; bit length = {cnt, 3'b000}
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   bus       md5_padder_if.slave (byte stream in, block stream out)
//   msg_count [15:0] completed-message counter, present only when
//             MD5_PADDER_STATS_EN is defined
//
// When the final byte leaves no room for the length field (position 55..63)
// the current block goes out without it and a second, EXTRA-built block
// carries the length (and the 0x80 marker if it did not fit).
module md5_padder
  import md5_pkg::*;
#(
  parameter int CNT_W = 61
) (
  input  logic clk,
  input  logic reset_n,
  md5_padder_if.slave bus
`ifdef MD5_PADDER_STATS_EN
  ,
  output logic [15:0] msg_count
`endif
);

  md5_state_e       state_q, state_n;
  logic [5:0]       idx_q, idx_n, nxt_pos;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  md5_block_t       blk_q, blk_n;
  logic             last_q, last_n;
  logic             extra_q, extra_n;
  logic             placed_q, placed_n;
  logic             run_q;
  logic             s_ready;
  logic             s_hs, blk_hs;

  function automatic logic [63:0] bit_len(input logic [CNT_W-1:0] c);
    return 64'({c, 3'b000});
  endfunction

  // s_ready stays low while reset is held and during the first cycle after.
  assign s_ready       = run_q && (state_q == FILL);
  assign s_hs          = bus.s_valid && s_ready;
  assign blk_hs        = (state_q == EMIT) && bus.blk_ready;
  assign cnt_inc       = cnt_q + 1'b1;
  assign nxt_pos       = idx_q + 6'd1;

  assign bus.s_ready   = s_ready;
  assign bus.blk_valid = (state_q == EMIT);
  assign bus.blk_last  = last_q;
  assign bus.blk_data  = blk_q;

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    cnt_n    = cnt_q;
    blk_n    = blk_q;
    last_n   = last_q;
    extra_n  = extra_q;
    placed_n = placed_q;

    case (state_q)
      FILL: begin
        if (s_hs) begin
          // Bytes past idx are still zero: the buffer is cleared on every
          // return to FILL, so only the marker and length need writing.
          blk_n[~idx_q] = bus.s_data;
          cnt_n         = cnt_inc;
          idx_n         = nxt_pos;
          if (bus.s_last) begin
            idx_n   = '0;
            state_n = EMIT;
            if (idx_q != 6'(MD5_BLOCK_BYTES - 1)) begin
              blk_n[~nxt_pos] = MD5_PAD_BYTE;
            end
            if (idx_q <= 6'(MD5_LEN_POS - 2)) begin
              blk_n  = md5_insert_len(blk_n, bit_len(cnt_inc));
              last_n = 1'b1;
            end else begin
              last_n   = 1'b0;
              extra_n  = 1'b1;
              placed_n = (idx_q != 6'(MD5_BLOCK_BYTES - 1));
            end
          end else if (idx_q == 6'(MD5_BLOCK_BYTES - 1)) begin
            state_n = EMIT;
            last_n  = 1'b0;
          end
        end
      end

      EMIT: begin
        if (blk_hs) begin
          if (extra_q) begin
            state_n = EXTRA;
          end else begin
            state_n = FILL;
            blk_n   = '0;
            if (last_q) begin
              cnt_n  = '0;
              last_n = 1'b0;
            end
          end
        end
      end

      EXTRA: begin
        blk_n = '0;
        if (!placed_q) begin
          blk_n[63] = MD5_PAD_BYTE;
        end
        blk_n    = md5_insert_len(blk_n, bit_len(cnt_q));
        last_n   = 1'b1;
        extra_n  = 1'b0;
        placed_n = 1'b0;
        state_n  = EMIT;
      end

      default: begin
        state_n = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FILL;
      idx_q    <= '0;
      cnt_q    <= '0;
      blk_q    <= '0;
      last_q   <= 1'b0;
      extra_q  <= 1'b0;
      placed_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      cnt_q    <= cnt_n;
      blk_q    <= blk_n;
      last_q   <= last_n;
      extra_q  <= extra_n;
      placed_q <= placed_n;
      run_q    <= 1'b1;
    end
  end

`ifdef MD5_PADDER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_count <= '0;
    end else if (blk_hs && last_q) begin
      msg_count <= msg_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/md5_padder.md
MD5_PADDER -- requirements
Module: md5_padder

Interface
REQ-001 SHALL have parameter CNT_W, default 61, width of the message byte counter; the emitted bit length is {cnt, 3'b000}, zero-extended to 64 bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port s_data  input  8  message byte.
REQ-005 SHALL have port s_valid  input  1  s_data valid.
REQ-006 SHALL have port s_last  input  1  s_data is the final byte of the message.
REQ-007 SHALL have port s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-008 SHALL have port blk_data  output  512  padded block; message byte k of the block sits at [511-8k -: 8], which is the layout the md5 core consumes.
REQ-009 SHALL have port blk_valid  output  1  blk_data valid.
REQ-010 SHALL have port blk_last  output  1  block is the final block of the message.
REQ-011 SHALL have port blk_ready  input  1  block consumed when blk_valid && blk_ready.

Function
REQ-012 SHALL implement states FILL, EMIT and EXTRA, with a 6-bit byte index idx and a CNT_W-bit message byte counter cnt.
REQ-013 FILL: s_ready=1, blk_valid=0; each accepted byte is written at position idx, then idx and cnt increment.
REQ-014 FILL, accepted byte at idx=63 with s_last=0: go to EMIT with blk_last=0; idx wraps to 0.
REQ-015 FILL, accepted byte at position p with s_last=1 and p<=54: write 0x80 at p+1, zeros at p+2..55, and the 64-bit little-endian bit length at bytes 56..63 (byte 56 = LSB); go to EMIT with blk_last=1.
REQ-016 FILL, accepted byte at p with s_last=1 and 55<=p<=63: write 0x80 at p+1 only if p<63, and zeros at the remaining bytes; go to EMIT with blk_last=0 and set an extra-pending flag plus a flag recording whether 0x80 was already placed.
REQ-017 Bit length SHALL include the final byte (cnt+1 at the last handshake).
REQ-018 EMIT: s_ready=0, blk_valid=1, and blk_data/blk_last hold stable until blk_ready.
REQ-019 EMIT exit on handshake: to EXTRA if extra-pending, else to FILL; on the FILL path the buffer clears, and cnt clears if blk_last was 1.
REQ-020 EXTRA: build a block of 0x80 at byte 0 (only if not already placed), zeros elsewhere, and the length at 56..63; the next cycle is EMIT with blk_last=1 and extra-pending cleared.
REQ-021 Latency: blk_valid SHALL rise the cycle after the completing byte handshake (two cycles for the extra block), and s_ready returns the cycle after the final blk handshake.
REQ-022 A new message's first byte SHALL be accepted directly after blk_last completes; no idle cycle is required.
REQ-023 cnt overflow SHALL wrap modulo 2^CNT_W without error.
REQ-024 Zero-length messages are not supported; s_last qualifies a real byte.

Reset
REQ-025 reset_n low SHALL asynchronously force state FILL, idx=0, cnt=0, buffer=0, flags=0, s_ready=0 during reset, blk_valid=0, blk_last=0 and blk_data=0; s_ready=1 from the first clock after release.
REQ-026 A reset mid-message or mid-EMIT SHALL discard all partial data; no block is emitted afterwards.

Configuration
REQ-027 With MD5_PADDER_STATS_EN defined, SHALL add output msg_count [15:0] (reset 0) incrementing on each blk_last handshake and wrapping at 0xFFFF.
REQ-028 Without MD5_PADDER_STATS_EN, the port and counter SHALL be absent and the rest of the behaviour is identical.

Structure
REQ-029 Shared package md5_pkg SHALL hold the state enum, MD5_BLOCK_BYTES=64, MD5_LEN_POS=56 and MD5_PAD_BYTE=8'h80.
REQ-030 Single flat module, no sub-module; the length-insertion logic is a function in md5_pkg.

Verification
REQ-031 "abc" (61 62 63, last on 63) -> one block 61 62 63 80, zeros, byte56=0x18, blk_last=1; fed to the md5 core, digest = 900150983cd24fb0d6963f7d28e17f72.
REQ-032 55 bytes of 0x41 -> one block, byte55=0x80, byte56=0xB8, byte57=0x01, blk_last=1.
REQ-033 56 bytes of 0x41 -> block 1: byte56=0x80, rest zero, blk_last=0; block 2: all zero except byte56=0xC0, byte57=0x01, blk_last=1.
REQ-034 64 bytes of 0x00 -> block 1 = data with blk_last=0; block 2 = byte0 0x80, byte56=0x00, byte57=0x02, blk_last=1.
REQ-035 "abc" with blk_ready held low for 10 cycles -> blk_data stable, s_ready=0 throughout; the handshake occurs on the cycle blk_ready rises.
REQ-036 reset_n pulsed low after 30 bytes of a message, then "abc" -> only the "abc" block from REQ-031 is emitted.
